// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: instruction memory req/ack, downstream redirect and the
// decode-side valid/ready port. The fetch unit connects as master.
interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        redirect;
    logic [31:0] redirect_pc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus_four;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instruction,
        output out_pc,
        output out_pc_plus_four
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instruction,
        input  out_pc,
        input  out_pc_plus_four
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Purpose: MIPS fetch stage; one outstanding imem read feeding an in-order prefetch buffer.
// Latency: request one cycle after reset/redirect, head valid one cycle after the ack.
// Backpressure: no new request is started while the buffer is full; out_ready=0 holds the head.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic                      clock,
    input logic                      reset,
    instruction_fetch_unit_if.master bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [31:0]      fetch_pc, fetch_pc_next;
    logic [31:0]      stale_addr, stale_addr_next;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
    logic [CNT_W-1:0] count, count_next, count_step;
    logic             push, pop;

    logic [31:0]      buf_instr [DEPTH];
    logic [31:0]      buf_pc    [DEPTH];

    always_comb begin
        push       = (state == BUSY) && bus.imem_ack && !bus.redirect;
        pop        = (count != '0) && bus.out_ready && !bus.redirect;
        count_step = count + CNT_W'(push) - CNT_W'(pop);

        state_next      = state;
        fetch_pc_next   = fetch_pc;
        stale_addr_next = stale_addr;
        rd_ptr_next     = rd_ptr;
        wr_ptr_next     = wr_ptr;
        count_next      = count_step;

        if (bus.redirect) begin
            count_next    = '0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            fetch_pc_next = bus.redirect_pc & 32'hFFFF_FFFC;
            // An unacked request cannot be withdrawn; keep presenting its address until it retires.
            if ((state == BUSY || state == DRAIN) && !bus.imem_ack) begin
                state_next = DRAIN;
                if (state == BUSY) begin
                    stale_addr_next = fetch_pc;
                end
            end else begin
                state_next = BUSY;
            end
        end else begin
            if (push) begin
                wr_ptr_next   = wr_ptr + PTR_W'(1);
                fetch_pc_next = fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + PTR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (count < DEPTH_C) begin
                        state_next = BUSY;
                    end
                end
                BUSY: begin
                    if (bus.imem_ack) begin
                        state_next = (count_step < DEPTH_C) ? BUSY : IDLE;
                    end
                end
                DRAIN: begin
                    if (bus.imem_ack) begin
                        state_next = BUSY;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            stale_addr <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            stale_addr <= stale_addr_next;
            rd_ptr     <= rd_ptr_next;
            wr_ptr     <= wr_ptr_next;
            count      <= count_next;
        end
    end

    // Entries are cleared on reset so the head reads as zero before the first fill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (push) begin
            buf_instr[wr_ptr] <= bus.imem_rdata;
            buf_pc[wr_ptr]    <= fetch_pc;
        end
    end

    assign bus.imem_req         = (state != IDLE);
    assign bus.imem_addr        = (state == DRAIN) ? stale_addr : fetch_pc;
    assign bus.out_valid        = (count != '0);
    assign bus.out_instruction  = buf_instr[rd_ptr];
    assign bus.out_pc           = buf_pc[rd_ptr];
    assign bus.out_pc_plus_four = buf_pc[rd_ptr] + 32'd4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: wait-state memory model, redirect-aware
// expected instruction stream, directed timing checks and randomized traffic.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    instruction_fetch_unit_if bus_if();

    instruction_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    int          vectors     = 0;
    int          miscompares = 0;
    int          pops        = 0;
    int          mem_mode    = 0;
    int          wait_states = 0;
    logic [31:0] mem_key     = 32'h0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Program order after a restart is simply consecutive words from the target.
    function automatic void model_restart(input logic [31:0] pc);
        logic [31:0] p;
        p = pc & 32'hFFFF_FFFC;
        exp_q.delete();
        for (int i = 0; i < 2048; i++) begin
            exp_q.push_back(p);
            p = p + 32'd4;
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        model_restart(RESET_PC);
    endtask

    // Memory: fixed wait states (mode 0) or random ack every cycle (mode 1).
    initial begin
        int wcnt;
        wcnt = 0;
        bus_if.imem_ack   = 1'b0;
        bus_if.imem_rdata = 32'h0;
        forever begin
            @(posedge clock);
            #2;
            if (mem_mode == 1) begin
                bus_if.imem_ack   = 1'($urandom_range(0, 1));
                bus_if.imem_rdata = (bus_if.imem_req && bus_if.imem_ack) ?
                                    (bus_if.imem_addr ^ mem_key) : $urandom;
                wcnt = 0;
            end else if (bus_if.imem_req) begin
                if (wcnt >= wait_states) begin
                    bus_if.imem_ack   = 1'b1;
                    bus_if.imem_rdata = bus_if.imem_addr ^ mem_key;
                    wcnt = 0;
                end else begin
                    bus_if.imem_ack   = 1'b0;
                    bus_if.imem_rdata = $urandom;
                    wcnt++;
                end
            end else begin
                bus_if.imem_ack   = 1'b0;
                bus_if.imem_rdata = $urandom;
                wcnt = 0;
            end
        end
    end

    // Monitor: request-hold protocol and in-order scoreboard on every pop.
    initial begin
        logic        prev_req, prev_ack, prev_rst;
        logic [31:0] prev_addr, e;
        prev_req = 1'b0; prev_ack = 1'b0; prev_rst = 1'b0; prev_addr = 32'h0;
        forever begin
            @(negedge clock);
            if (reset && prev_rst && prev_req && !prev_ack) begin
                check("imem_req_held", 32'(bus_if.imem_req), 32'd1);
                check("imem_addr_stable", bus_if.imem_addr, prev_addr);
            end
            if (reset && bus_if.out_valid && bus_if.out_ready && !bus_if.redirect) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underrun", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_out_pc", bus_if.out_pc, e);
                    check("sb_out_instruction", bus_if.out_instruction, e ^ mem_key);
                    check("sb_out_pc_plus_four", bus_if.out_pc_plus_four, e + 32'd4);
                end
                pops++;
            end
            prev_req  = bus_if.imem_req;
            prev_ack  = bus_if.imem_ack;
            prev_addr = bus_if.imem_addr;
            prev_rst  = reset;
        end
    end

    initial begin
        #2_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int start, n;
        bit hit;
        bus_if.out_ready   = 1'b0;
        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = 32'h0;

        // Reset values
        #1 reset = 1'b0;
        #2;
        check("rst_imem_req", 32'(bus_if.imem_req), 32'd0);
        check("rst_imem_addr", bus_if.imem_addr, RESET_PC);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_out_pc", bus_if.out_pc, 32'h0);
        check("rst_out_instruction", bus_if.out_instruction, 32'h0);
        check("rst_out_pc_plus_four", bus_if.out_pc_plus_four, 32'h4);

        // Startup, zero-wait memory, one instruction per cycle
        tick();
        tick();
        reset = 1'b1;
        model_restart(RESET_PC);
        bus_if.out_ready = 1'b1;
        tick();
        check("start_req_edge1", 32'(bus_if.imem_req), 32'd1);
        check("start_addr_edge1", bus_if.imem_addr, RESET_PC);
        check("start_valid_edge1", 32'(bus_if.out_valid), 32'd0);
        tick();
        check("start_valid_edge2", 32'(bus_if.out_valid), 32'd1);
        check("start_pc_edge2", bus_if.out_pc, RESET_PC);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("stream_valid", 32'(bus_if.out_valid), 32'd1);
            check("stream_pc", bus_if.out_pc, RESET_PC + 32'(4 * k));
            check("stream_instr", bus_if.out_instruction, RESET_PC + 32'(4 * k));
        end

        // Buffer fill: request stops at DEPTH entries, resumes at +8
        bus_if.out_ready = 1'b0;
        apply_reset();
        tick();
        tick();
        check("fill_first_valid", 32'(bus_if.out_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("fill_req_low", 32'(bus_if.imem_req), 32'd0);
            check("fill_head_pc", bus_if.out_pc, RESET_PC);
            check("fill_fetch_addr", bus_if.imem_addr, RESET_PC + 32'd8);
        end
        bus_if.out_ready = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            hit = bus_if.imem_req;
        end
        check("fill_resume_req", 32'(hit), 32'd1);
        check("fill_resume_addr", bus_if.imem_addr, RESET_PC + 32'd8);
        repeat (10) tick();

        // Redirect during a 3-wait-state request leaves it draining
        wait_states = 3;
        apply_reset();
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            hit = bus_if.imem_req && (bus_if.imem_addr == RESET_PC + 32'd8);
        end
        check("drain_saw_req8", 32'(hit), 32'd1);
        tick();
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h0000_0040;
        model_restart(32'h0000_0040);
        tick();
        bus_if.redirect = 1'b0;
        check("drain_addr_hold1", bus_if.imem_addr, RESET_PC + 32'd8);
        check("drain_req_hold1", 32'(bus_if.imem_req), 32'd1);
        tick();
        check("drain_addr_hold2", bus_if.imem_addr, RESET_PC + 32'd8);
        tick();
        check("drain_new_addr", bus_if.imem_addr, 32'h0000_0040);
        check("drain_new_req", 32'(bus_if.imem_req), 32'd1);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            hit = bus_if.out_valid;
        end
        check("drain_valid_seen", 32'(hit), 32'd1);
        check("drain_first_pc", bus_if.out_pc, 32'h0000_0040);

        // Redirect coinciding with an ack and a pop
        wait_states = 0;
        repeat (8) tick();
        check("coinc_pre_valid", 32'(bus_if.out_valid), 32'd1);
        check("coinc_pre_req", 32'(bus_if.imem_req), 32'd1);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h0000_0100;
        model_restart(32'h0000_0100);
        tick();
        bus_if.redirect = 1'b0;
        check("coinc_valid_cleared", 32'(bus_if.out_valid), 32'd0);
        check("coinc_req", 32'(bus_if.imem_req), 32'd1);
        check("coinc_addr", bus_if.imem_addr, 32'h0000_0100);
        tick();
        check("coinc_valid", 32'(bus_if.out_valid), 32'd1);
        check("coinc_pc", bus_if.out_pc, 32'h0000_0100);

        // Unaligned redirect near the top of the address space
        repeat (3) tick();
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'hFFFF_FFFE;
        model_restart(32'hFFFF_FFFE);
        tick();
        bus_if.redirect = 1'b0;
        check("wrap_fetch_addr", bus_if.imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_out_pc", bus_if.out_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus_four", bus_if.out_pc_plus_four, 32'h0);
        check("wrap_next_addr", bus_if.imem_addr, 32'h0);
        repeat (4) tick();

        // Asynchronous reset in the middle of a wait-stated request
        wait_states = 3;
        bus_if.out_ready = 1'b0;
        apply_reset();
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            tick();
            hit = bus_if.out_valid;
        end
        check("arst_pre_valid", 32'(hit), 32'd1);
        tick();
        check("arst_pre_req", 32'(bus_if.imem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_req", 32'(bus_if.imem_req), 32'd0);
        check("arst_valid", 32'(bus_if.out_valid), 32'd0);
        check("arst_out_pc", bus_if.out_pc, 32'h0);
        check("arst_addr", bus_if.imem_addr, RESET_PC);
        mem_key = 32'h5A5A_A5A5;
        tick();
        tick();
        reset = 1'b1;
        model_restart(RESET_PC);
        bus_if.out_ready = 1'b1;
        tick();
        check("arst_restart_req", 32'(bus_if.imem_req), 32'd1);
        check("arst_restart_addr", bus_if.imem_addr, RESET_PC);

        // Randomized traffic: wait states, random acks, backpressure, redirects
        for (int p = 0; p < 4; p++) begin
            mem_mode    = p % 2;
            wait_states = p;
            repeat (600) begin
                tick();
                bus_if.redirect  = 1'b0;
                bus_if.out_ready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 31) == 0) begin
                    bus_if.redirect    = 1'b1;
                    bus_if.redirect_pc = $urandom;
                    model_restart(bus_if.redirect_pc);
                end
            end
        end

        // Final drain: forward progress at full rate
        mem_mode    = 0;
        wait_states = 0;
        tick();
        bus_if.out_ready   = 1'b1;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h0000_2000;
        model_restart(32'h0000_2000);
        tick();
        bus_if.redirect = 1'b0;
        start = pops;
        n = 0;
        while (n < 60 && (pops - start) < 20) begin
            tick();
            n++;
        end
        check("drain_progress", 32'((pops - start) >= 20), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage for the five-stage MIPS pipeline. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake that tolerates wait states. Returned words go into a small in-order prefetch buffer, which the decode stage drains through a valid/ready interface. A branch/jump redirect from downstream flushes the buffer and discards any in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0
- DEPTH, 2, prefetch buffer entries; power of two, ≥ 2
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  read request; held high until imem_ack
- imem_addr  out  32  word address of the current request; stable while imem_req=1
- imem_ack  in  1  completes the current request in the same cycle; ignored when imem_req=0
- imem_rdata  in  32  instruction word; valid when imem_req && imem_ack
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] are forced to 0
- out_valid  out  1  buffer head is valid
- out_ready  in  1  decode accepts head; a pop occurs when out_valid && out_ready
- out_instruction  out  32  head instruction word
- out_pc  out  32  address of the head instruction
- out_pc_plus_four  out  32  out_pc + 4, modulo 2^32

## Operation
- State register values: IDLE (no request), BUSY (request at fetch_pc; result is kept), DRAIN (stale request outstanding; result is discarded).
- imem_req = (state != IDLE). imem_addr = fetch_pc in BUSY and IDLE. In DRAIN, imem_addr holds the stale address latched when DRAIN was entered.
- At most one request is outstanding. An issued request is never withdrawn.
- Buffer: circular, DEPTH entries of {instruction, pc}. rd_ptr, wr_ptr and count are registered; count ranges 0..DEPTH.
- Let push = (state==BUSY && imem_ack && !redirect). Let pop = out_valid && out_ready && !redirect.
- count_next = count + push − pop.
- A push writes {imem_rdata, fetch_pc}, then fetch_pc increments by 4, wrapping 0xFFFF_FFFC to 0.
- Transitions when redirect = 0:
  - IDLE → BUSY if count < DEPTH.
  - BUSY with ack → BUSY if count_next < DEPTH, else IDLE.
  - BUSY without ack → BUSY.
  - DRAIN with ack → BUSY. The buffer is empty after a flush, so space is guaranteed.
  - DRAIN without ack → DRAIN.
- Redirect takes priority over all other events in that cycle:
  - count, rd_ptr and wr_ptr are cleared to 0, and fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - The cycle's push and pop are suppressed. The decode handshake in that cycle is don't-care.
  - State goes to DRAIN if state==BUSY && !imem_ack, or if state==DRAIN && !imem_ack. Otherwise it goes to BUSY.
  - Data returned in the redirect cycle is discarded.
  - A redirect while in DRAIN updates fetch_pc again and stays in DRAIN until ack.
- out_valid = (count != 0). out_instruction and out_pc come from buffer[rd_ptr]. out_pc_plus_four = out_pc + 4, wrapping.
- The buffer never overflows: a request is only started when count < DEPTH, and pops only free space.

## Timing
- Reset (reset = 0, takes effect immediately):
  - state = IDLE, fetch_pc = RESET_PC, count = rd_ptr = wr_ptr = 0.
  - Outputs: imem_req = 0, imem_addr = RESET_PC, out_valid = 0. out_instruction, out_pc and buffer contents = 0, so out_pc_plus_four = 4.
- Reset asserted mid-request drops the request immediately. The memory model must tolerate this.
- Startup with zero-wait memory (ack tied high), counting edges after reset release:
  - edge 1: IDLE → BUSY.
  - cycle after edge 1: imem_req = 1 and the fetch completes.
  - after edge 2: out_valid = 1 with out_pc = RESET_PC.
- Steady state with zero-wait memory and out_ready = 1: one instruction per cycle.
- Redirect latency with zero-wait memory: redirect sampled at edge N; request at the new pc in cycle N+1; out_valid = 1 after edge N+2.
- With W wait states, each fetch occupies W+1 cycles of imem_req.
- A redirect that leaves a stale request adds that request's remaining cycles before the new fetch starts.
- No combinational path from imem_ack or imem_rdata to any output. out_valid depends only on registers.

## Test plan
- Reset release; zero-wait memory returning rdata = addr; out_ready = 1 → out_pc = 0, 4, 8, 12 on consecutive cycles starting after edge 2, with out_instruction equal to out_pc.
- DEPTH = 2; out_ready = 0 for 6 cycles after first valid → count reaches 2 and imem_req falls. Then set out_ready = 1 → outputs continue 0, 4, 8, … in order with no gaps or duplicates, and imem_addr resumes at 8.
- Memory with 3 wait states; redirect to 0x40 one cycle into a request for 0x8 → imem_addr holds 0x8 until ack, then moves to 0x40. Word 0x8 never appears; the first out_pc after the flush is 0x40.
- Redirect to 0x100 in the same cycle as imem_ack and an out_valid && out_ready pop → count = 0 next cycle, no stale output, and the next request address is 0x100.
- Redirect to 0xFFFF_FFFE → fetch at 0xFFFF_FFFC. Its output shows out_pc_plus_four = 0, and the next imem_addr is 0x0.
- Drive reset low asynchronously mid-cycle during a wait-stated request with count = 1 → imem_req = 0 and out_valid = 0 before the next edge. After release, fetch restarts at RESET_PC.
